mem_arbiter: RTL
================

# mem_arbiter

Two-requester access scheduler for the shared unified instruction/data memory of the multi-cycle MIPS core. It sits between the fetch path and the load/store path on one side and the single memory port (`we`, `a`, `wd`, `rd`) on the other. It accepts one request at a time, registers its address and data, and drives the memory for exactly one cycle. Read data comes back through a registered per-requester response.

## Interface
Parameters:
- `STARVE_MAX`, default 4: maximum consecutive contested data grants before fetch is forced to win. Used in fixed-priority mode only.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; read only.
- `i_addr`  in  32  fetch byte address.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_rvalid`  out  1  `i_rdata` valid, one-cycle pulse.
- `i_rdata`  out  32  fetched instruction word.
- `d_req`  in  1  data request.
- `d_we`  in  1  data request is a write.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  `d_rdata` valid, one-cycle pulse; reads only.
- `d_rdata`  out  32  load data.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  32  memory byte address; bits [1:0] are always 0.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory combinational read data.

## Operation
States:
- IDLE: examine requests.
- ACC: drive the memory.

IDLE behaviour:
- If any request is high, grant exactly one requester: a combinational `x_gnt` pulse in that cycle.
- At the edge ending that cycle, latch address (bits [1:0] zeroed), write data, write flag and owner, then go to ACC.
- With no request, stay in IDLE.

ACC behaviour:
- `mem_a` and `mem_wd` present the latched values.
- `mem_we` = latched write flag.
- At the edge ending ACC:
  - Read: latch `mem_rd` into the owner's `x_rdata` and pulse the owner's `x_rvalid` next cycle.
  - Write: no response.
- Return to IDLE unconditionally. Grants are only issued in IDLE.

Requester rules:
- Hold `req`, `addr`, `we` and `wdata` stable until `gnt`.
- `req` still high in the cycle after `gnt` is treated as a new request.

Arbitration (default, fixed priority):
- Data beats fetch.
- A 3-bit saturating counter `starve` counts data grants made while `i_req` was also high.
- When `starve == STARVE_MAX` and both request, fetch wins and `starve` clears.
- Any uncontested grant, or any fetch grant, clears `starve`.

Other rules:
- `x_rdata` holds its value until the next read response for that requester.
- `mem_a` and `mem_wd` hold their last latched value in IDLE.
- `mem_we` is 0 everywhere except ACC-with-write.

Reset (`reset_n` low, at any time including mid-ACC):
- State goes to IDLE immediately.
- `mem_we`, `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid` = 0.
- `mem_a`, `mem_wd`, `i_rdata`, `d_rdata` = 0.
- `starve` = 0; the round-robin pointer selects data.
- An in-flight write is aborted; an in-flight read gives no response.

## Timing
- Request seen in IDLE at cycle N: `gnt` high in N, memory driven in N+1, `rvalid` high in N+2.
- Read latency is 2 cycles from acceptance.
- Peak throughput is 1 access per 2 cycles. A new grant may coincide with the previous `rvalid` in N+2.
- `x_gnt` is combinational from state and requests; every other output is registered.
- At most one `x_gnt` is high in any cycle. Never both `i_rvalid` and `d_rvalid`.

## Configuration
- `MEMARB_RR_EN` defined:
  - Round-robin replaces fixed priority. A 1-bit pointer names the last-granted requester.
  - On contention, the other requester wins.
  - The pointer updates on every grant.
  - `starve` logic and `STARVE_MAX` are unused.
- Undefined: fixed data priority with the starvation counter, as above.

## Test plan
- Single fetch, `i_addr`=0x00000008, memory word 2 = 0x20080005 → `i_gnt` at N, `mem_a`=0x8 and `mem_we`=0 at N+1, `i_rvalid`=1 and `i_rdata`=0x20080005 at N+2.
- Data write `d_addr`=0x0000004C, `d_wdata`=0x00000007 → `mem_we`=1 for exactly one cycle (N+1) with `mem_a`=0x4C; no `d_rvalid`. A following read of 0x4C returns 0x00000007.
- Misaligned `d_addr`=0x00000053 read → `mem_a`=0x50.
- Both requesters held high continuously:
  - Fixed mode, `STARVE_MAX`=4: grant sequence D,D,D,D,I repeating.
  - With `MEMARB_RR_EN`: D,I,D,I alternating.
- `reset_n` pulled low mid-ACC of a write to 0x10 → `mem_we` drops asynchronously, word 0x10 unchanged, all outputs 0, next request granted normally after release.
- Fetch re-requests in the cycle after `i_gnt` → second `i_gnt` at N+2 coincides with the first `i_rvalid`; responses return in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) scheduler for a single shared memory port.
// Define MEMARB_RR_EN for round-robin arbitration; default is data priority with starvation guard.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // state | meaning
  // IDLE  | examine requests, issue at most one grant
  // ACC   | drive the latched access onto the memory port
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic        sel_i, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        own_d_q, own_d_d;
  logic        mem_we_q, mem_we_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
`ifdef MEMARB_RR_EN
  logic        last_i_q, last_i_d;
`else
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0]  starve_q, starve_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wd_q       <= '0;
      own_d_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef MEMARB_RR_EN
      last_i_q   <= 1'b1;
`else
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      own_d_q    <= own_d_d;
      mem_we_q   <= mem_we_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEMARB_RR_EN
      last_i_q   <= last_i_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  // Arbitration; gated by reset_n so no grant escapes while reset is held.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (state_q == IDLE && reset_n) begin
`ifdef MEMARB_RR_EN
      if (i_req && d_req) begin
        sel_d = last_i_q;
        sel_i = !last_i_q;
      end
`else
      if (i_req && d_req) begin
        sel_i = (starve_q == STARVE_LIM);
        sel_d = !sel_i;
      end
`endif
      else begin
        sel_i = i_req;
        sel_d = d_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_i || sel_d) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wd_d       = wd_q;
    own_d_d    = own_d_q;
    mem_we_d   = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEMARB_RR_EN
    last_i_d   = last_i_q;
`else
    starve_d   = starve_q;
`endif
    if (sel_d) begin
      addr_d   = d_addr & WORD_MASK;
      wd_d     = d_wdata;
      own_d_d  = 1'b1;
      mem_we_d = d_we;
    end else if (sel_i) begin
      addr_d   = i_addr & WORD_MASK;
      own_d_d  = 1'b0;
    end
`ifdef MEMARB_RR_EN
    if (sel_i) last_i_d = 1'b1;
    else if (sel_d) last_i_d = 1'b0;
`else
    // Only data grants won against a waiting fetch advance the counter.
    if (sel_d && i_req) starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    else if (sel_d || sel_i) starve_d = '0;
`endif
    if (state_q == ACC && !mem_we_q) begin
      if (own_d_q) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_rd;
      end else begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = mem_rd;
      end
    end
  end

  always_comb begin
    i_gnt    = sel_i;
    d_gnt    = sel_d;
    mem_we   = mem_we_q;
    mem_a    = addr_q;
    mem_wd   = wd_q;
    i_rvalid = i_rvalid_q;
    d_rvalid = d_rvalid_q;
    i_rdata  = i_rdata_q;
    d_rdata  = d_rdata_q;
  end

endmodule
